// File: rtl/pocket_brg_arb.sv
// Round-robin arbiter and sequencer sharing one 2-bit bridge SPI shifter among NREQ requesters.
// Drives slave select and clock enable with setup/hold/gap timing and collects 32-bit read data.
module pocket_brg_arb #(
  parameter int NREQ  = 4,
  parameter int SETUP = 2,
  parameter int HOLD  = 2,
  parameter int GAP   = 4,
  parameter int TMO   = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [64*NREQ-1:0]   cmd,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic [31:0]          rdata,
  output logic                 rd_valid,
  output logic                 sh_wr,
  output logic [63:0]          sh_din,
  input  logic                 sh_idle,
  input  logic                 sh_rding,
  input  logic [1:0]           spi_in,
  output logic                 spiss,
  output logic                 spi_cen
);

  localparam int PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW      = $clog2(TMO + 1);
  localparam int SETUP_C = (SETUP < 1) ? 1 : SETUP;
  localparam int HOLD_C  = (HOLD < 1) ? 1 : HOLD;
  localparam int GAP_C   = (GAP < 1) ? 1 : GAP;
  localparam int PMAX    = (SETUP_C > HOLD_C) ? ((SETUP_C > GAP_C) ? SETUP_C : GAP_C)
                                              : ((HOLD_C > GAP_C) ? HOLD_C : GAP_C);
  localparam int CW      = $clog2(PMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]     tim_q, tim_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [4:0]        pair_q, pair_d;
  logic [31:0]       shift_q, shift_d;
  logic              abort_q, abort_d;
  logic              short_q, short_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              err_q, err_d;
  logic              rd_valid_q, rd_valid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [63:0]       sh_din_q, sh_din_d;
  logic              sh_wr_q, sh_wr_d;
  logic              spiss_q, spiss_d;
  logic              spi_cen_q, spi_cen_d;

  logic [PW-1:0]     sel;
  logic [PW-1:0]     cand;
  logic              found;
  logic              is_rd;
  logic              bad;

  assign is_rd = ~sh_din_q[32];

  // Search upward from rr_ptr+1, wrapping, so the last winner is considered last.
  always_comb begin
    found = 1'b0;
    sel   = rr_ptr_q;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PW'((int'(rr_ptr_q) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    tim_d      = tim_q;
    tmo_d      = tmo_q;
    pair_d     = pair_q;
    shift_d    = shift_q;
    abort_d    = abort_q;
    short_d    = short_q;
    rdata_d    = rdata_q;
    sh_din_d   = sh_din_q;
    gnt_d      = '0;
    done_d     = '0;
    err_d      = 1'b0;
    rd_valid_d = 1'b0;
    bad        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d[sel] = 1'b1;
          sh_din_d   = cmd[64*int'(sel) +: 64];
          rr_ptr_d   = sel;
          pair_d     = '0;
          shift_d    = '0;
          abort_d    = 1'b0;
          short_d    = 1'b0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        tim_d   = '0;
        state_d = S_SETUP;
      end
      S_SETUP: begin
        if (tim_q == CW'(SETUP_C - 1)) begin
          // A shifter already idle here never started: the transfer is short.
          short_d = sh_idle;
          tmo_d   = '0;
          state_d = S_SHIFT;
        end else begin
          tim_d = tim_q + 1'b1;
        end
      end
      S_SHIFT: begin
        tmo_d = tmo_q + 1'b1;
        if (is_rd && sh_rding) begin
          shift_d = {shift_q[29:0], spi_in};
          if (pair_q != 5'd16) pair_d = pair_q + 5'd1;
        end
        if (sh_idle) begin
          tim_d   = '0;
          state_d = S_HOLD;
        end else if (tmo_q == TW'(TMO - 1)) begin
          abort_d = 1'b1;
          tim_d   = '0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (tim_q == CW'(HOLD_C - 1)) begin
          bad              = abort_q | short_q | (is_rd && (pair_q != 5'd16));
          done_d[rr_ptr_q] = 1'b1;
          err_d            = bad;
          if (is_rd && !bad) begin
            rdata_d    = shift_q;
            rd_valid_d = 1'b1;
          end
          tim_d   = '0;
          state_d = (GAP > 0) ? S_GAP : S_IDLE;
        end else begin
          tim_d = tim_q + 1'b1;
        end
      end
      S_GAP: begin
        if (tim_q == CW'(GAP_C - 1)) state_d = S_IDLE;
        else                         tim_d   = tim_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    sh_wr_d   = (state_d == S_LOAD);
    spiss_d   = !((state_d == S_SETUP) || (state_d == S_SHIFT) || (state_d == S_HOLD));
    spi_cen_d = (state_d == S_SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      tim_q      <= '0;
      tmo_q      <= '0;
      pair_q     <= '0;
      shift_q    <= '0;
      abort_q    <= 1'b0;
      short_q    <= 1'b0;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rdata_q    <= '0;
      sh_din_q   <= '0;
      sh_wr_q    <= 1'b0;
      spiss_q    <= 1'b1;
      spi_cen_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      tim_q      <= tim_d;
      tmo_q      <= tmo_d;
      pair_q     <= pair_d;
      shift_q    <= shift_d;
      abort_q    <= abort_d;
      short_q    <= short_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      rdata_q    <= rdata_d;
      sh_din_q   <= sh_din_d;
      sh_wr_q    <= sh_wr_d;
      spiss_q    <= spiss_d;
      spi_cen_q  <= spi_cen_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign err      = err_q;
  assign rd_valid = rd_valid_q;
  assign rdata    = rdata_q;
  assign sh_din   = sh_din_q;
  assign sh_wr    = sh_wr_q;
  assign spiss    = spiss_q;
  assign spi_cen  = spi_cen_q;

endmodule

// File: tb/tb_pocket_brg_arb.sv
// Directed bench for pocket_brg_arb: a behavioural shifter plus a bus monitor, checked
// against hand-computed grant order, timing and read data.
module tb_pocket_brg_arb;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [64*NREQ-1:0] cmd;
  logic [NREQ-1:0]   gnt, done;
  logic              err, rd_valid, sh_wr;
  logic [31:0]       rdata;
  logic [63:0]       sh_din;
  logic              sh_idle, sh_rding;
  logic [1:0]        spi_in;
  logic              spiss, spi_cen;

  pocket_brg_arb #(.NREQ(NREQ), .SETUP(2), .HOLD(2), .GAP(4), .TMO(64)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .cmd(cmd), .gnt(gnt), .done(done),
    .err(err), .rdata(rdata), .rd_valid(rd_valid), .sh_wr(sh_wr), .sh_din(sh_din),
    .sh_idle(sh_idle), .sh_rding(sh_rding), .spi_in(spi_in), .spiss(spiss), .spi_cen(spi_cen)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Shifter model controls
  logic        stuck = 1'b0;
  int          rd_pairs = 16;
  logic [31:0] rd_word = '0;

  // Monitor state
  int              cyc = 0;
  logic [NREQ-1:0] gnt_log[$];
  int              hi_runs[$];
  logic [63:0]     din_at_wr = '0;
  int ss_low_run = 0, last_ss_low = 0, hi_run = 0;
  int cen_run = 0, last_cen = 0;
  int gnt_cyc = 0, cen_rise_cyc = 0, cen_fall_cyc = 0, done_cyc = 0;

  initial begin
    logic prev_ss, prev_cen;
    prev_ss = 1'b1;
    prev_cen = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (|gnt) begin
        gnt_log.push_back(gnt);
        gnt_cyc = cyc;
      end
      if (sh_wr) din_at_wr = sh_din;
      if (!spiss) begin
        if (prev_ss) hi_runs.push_back(hi_run);
        hi_run = 0;
        ss_low_run++;
      end else begin
        if (!prev_ss) last_ss_low = ss_low_run;
        ss_low_run = 0;
        hi_run++;
      end
      if (spi_cen) begin
        if (!prev_cen) cen_rise_cyc = cyc;
        cen_run++;
      end else if (prev_cen) begin
        last_cen = cen_run;
        cen_run = 0;
        cen_fall_cyc = cyc;
      end
      if (|done) done_cyc = cyc;
      prev_ss = spiss;
      prev_cen = spi_cen;
    end
  end

  // Behavioural shifter: busy after sh_wr, streams pairs MSB-first while spi_cen is high.
  initial begin
    int k, n, lim;
    logic is_rd_m;
    sh_idle = 1'b1;
    sh_rding = 1'b0;
    spi_in = 2'b00;
    forever begin
      @(negedge clk);
      if (sh_wr) begin
        is_rd_m = ~sh_din[32];
        lim = is_rd_m ? rd_pairs : 8;
        sh_idle = 1'b0;
        n = 0;
        while (!spi_cen && n < 100) begin
          @(negedge clk);
          n++;
        end
        k = 0;
        while (spi_cen && k < 200) begin
          if (stuck) begin
            sh_rding = 1'b0;
          end else if (k < lim) begin
            sh_rding = is_rd_m;
            spi_in = rd_word[31-2*k -: 2];
          end else begin
            sh_rding = 1'b0;
            sh_idle = 1'b1;
          end
          k++;
          @(negedge clk);
        end
        sh_rding = 1'b0;
        sh_idle = 1'b1;
      end
    end
  end

  task automatic wait_gnt(output logic [NREQ-1:0] g);
    int n;
    n = 0;
    while (gnt == '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (gnt == '0) begin
      checks++;
      errors++;
      $display("FAIL gnt_wait observed=none expected=grant within 200 cycles");
    end
    g = gnt;
  endtask

  task automatic wait_done(input int budget, output logic [NREQ-1:0] d, output logic e,
                           output logic v, output logic [31:0] r);
    int n;
    n = 0;
    while (done == '0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done == '0) begin
      checks++;
      errors++;
      $display("FAIL done_wait observed=none expected=done within %0d cycles", budget);
    end
    d = done;
    e = err;
    v = rd_valid;
    r = rdata;
  endtask

  initial begin
    logic [NREQ-1:0] g, d;
    logic e, v;
    logic [31:0] r;
    int s0, g0, mn, n;

    rst_n = 1'b0;
    req = '0;
    cmd = '0;
    repeat (3) @(negedge clk);
    chk("rst_spiss", spiss, 1'b1);
    chk("rst_spi_cen", spi_cen, 1'b0);
    chk("rst_sh_wr", sh_wr, 1'b0);
    chk("rst_gnt", gnt, '0);
    chk("rst_done", done, '0);
    chk("rst_err", err, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rdata", rdata, '0);
    chk("rst_sh_din", sh_din, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Round-robin with all requesters holding req (write commands)
    for (int i = 0; i < NREQ; i++) cmd[64*i +: 64] = {32'hF801_0001 + 32'(i << 4), 32'h1000_0000 + 32'(i)};
    s0 = hi_runs.size();
    g0 = gnt_log.size();
    req = 4'hF;
    n = 0;
    while (gnt_log.size() < g0 + 8 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    req = '0;
    wait_done(300, d, e, v, r);
    @(negedge clk);
    chk("rr_count", 64'(gnt_log.size() - g0), 64'd8);
    for (int k = 0; k < 8; k++)
      if (g0 + k < gnt_log.size()) chk($sformatf("rr_order%0d", k), gnt_log[g0+k], 4'b0001 << ((k + 1) % 4));
    mn = 1000;
    for (int k = s0; k < hi_runs.size(); k++) if (hi_runs[k] < mn) mn = hi_runs[k];
    chk("rr_gap_min_ge_GAP", 64'(mn >= 4), 64'd1);

    // Single read on requester 0
    rd_word = 32'hA5A5_1234;
    cmd[0 +: 64] = 64'hF800_0000_0000_0000;
    g0 = gnt_log.size();
    req = 4'b0001;
    wait_gnt(g);
    chk("rd_gnt", g, 4'b0001);
    req = '0;
    wait_done(300, d, e, v, r);
    @(negedge clk);
    chk("rd_done", d, 4'b0001);
    chk("rd_err", e, 1'b0);
    chk("rd_valid", v, 1'b1);
    chk("rd_rdata", r, 32'hA5A5_1234);
    chk("rd_gnt_once", 64'(gnt_log.size() - g0), 64'd1);
    chk("rd_spiss_low", 64'(last_ss_low), 64'd21);
    chk("rd_cen_high", 64'(last_cen), 64'd17);
    chk("rd_gnt_to_cen", 64'(cen_rise_cyc - gnt_cyc), 64'd3);
    chk("rd_idle_to_done", 64'(done_cyc - cen_fall_cyc), 64'd2);

    // Write on requester 1
    cmd[64 +: 64] = 64'hF800_0001_DEAD_BEEF;
    req = 4'b0010;
    wait_gnt(g);
    chk("wr_gnt", g, 4'b0010);
    req = '0;
    wait_done(300, d, e, v, r);
    @(negedge clk);
    chk("wr_sh_din", din_at_wr, 64'hF800_0001_DEAD_BEEF);
    chk("wr_done", d, 4'b0010);
    chk("wr_err", e, 1'b0);
    chk("wr_rd_valid", v, 1'b0);
    chk("wr_rdata_kept", r, 32'hA5A5_1234);

    // Timeout with the shifter stuck busy
    stuck = 1'b1;
    cmd[128 +: 64] = 64'hF800_0003_0000_0000;
    req = 4'b0100;
    wait_gnt(g);
    req = '0;
    wait_done(300, d, e, v, r);
    @(negedge clk);
    stuck = 1'b0;
    chk("tmo_done", d, 4'b0100);
    chk("tmo_err", e, 1'b1);
    chk("tmo_rd_valid", v, 1'b0);
    chk("tmo_cen_high", 64'(last_cen), 64'd64);
    chk("tmo_hold_to_done", 64'(done_cyc - cen_fall_cyc), 64'd2);

    // Short read: only 10 pairs
    rd_pairs = 10;
    rd_word = 32'h0F0F_F0F0;
    cmd[192 +: 64] = 64'hF800_0004_0000_0000;
    req = 4'b1000;
    wait_gnt(g);
    chk("short_gnt", g, 4'b1000);
    req = '0;
    wait_done(300, d, e, v, r);
    @(negedge clk);
    rd_pairs = 16;
    chk("short_done", d, 4'b1000);
    chk("short_err", e, 1'b1);
    chk("short_rd_valid", v, 1'b0);
    chk("short_rdata_kept", r, 32'hA5A5_1234);

    // Asynchronous reset in the middle of SHIFT
    rd_word = 32'h1357_9BDF;
    cmd[128 +: 64] = 64'hF800_0008_0000_0000;
    req = 4'b0100;
    wait_gnt(g);
    req = '0;
    n = 0;
    while (!spi_cen && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("mid_cen_before", spi_cen, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_spiss", spiss, 1'b1);
    chk("arst_spi_cen", spi_cen, 1'b0);
    chk("arst_sh_wr", sh_wr, 1'b0);
    chk("arst_gnt", gnt, '0);
    chk("arst_done", done, '0);
    chk("arst_rd_valid", rd_valid, 1'b0);
    chk("arst_rdata", rdata, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    cmd[0 +: 64] = 64'hF800_000C_0000_0000;
    req = 4'b0001;
    wait_gnt(g);
    chk("post_rst_gnt", g, 4'b0001);
    req = '0;
    wait_done(300, d, e, v, r);
    chk("post_rst_done", d, 4'b0001);
    chk("post_rst_err", e, 1'b0);
    chk("post_rst_rdata", r, 32'h1357_9BDF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
